multicycle_ctrl: RTL and testbench

//  Parametrised multicycle RV32I control FSM; sequences fetch/decode/execute/memory/writeback and drives datapath muxes.

---
 rtl/multicycle_ctrl.sv | 233 +++++++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// Multicycle RV32I control FSM: fetch/decode/execute/memory/writeback sequencing, memory-wait timeout and traps.
// Optional CSR state and csr_access port are built only when CU_ZICSR_EN is defined.
module multicycle_ctrl #(
   parameter int MEM_TIMEOUT = 255,
   parameter int TIMEOUT_W   = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       memory_response,
   input  logic [6:0] instruction_opcode,
   input  logic [2:0] instruction_funct3,
   input  logic       instruction_bit20,
   output logic       pc_write,
   output logic       pc_write_cond,
   output logic       ir_write,
   output logic       reg_write,
   output logic       memory_read,
   output logic       memory_write,
   output logic       lorD,
   output logic       memory_to_reg,
   output logic       is_immediate,
   output logic [1:0] pc_source,
   output logic [1:0] aluop,
   output logic [1:0] alu_src_a,
   output logic [1:0] alu_src_b,
   output logic       trap,
   output logic [3:0] trap_cause,
   output logic [4:0] state_dbg
`ifdef CU_ZICSR_EN
   ,
   output logic       csr_access
`endif
);

   typedef enum logic [4:0] {
      S_FETCH     = 5'd0,
      S_FETCH_ACK = 5'd1,
      S_DECODE    = 5'd2,
      S_MEMADR    = 5'd3,
      S_MEMREAD   = 5'd4,
      S_MEMWB     = 5'd5,
      S_MEMWRITE  = 5'd6,
      S_EXEC_R    = 5'd7,
      S_EXEC_I    = 5'd8,
      S_ALUWB     = 5'd9,
      S_JAL       = 5'd10,
      S_BRANCH    = 5'd11,
      S_JALR_PC   = 5'd12,
      S_JALR      = 5'd13,
      S_AUIPC     = 5'd14,
      S_LUI       = 5'd15,
      S_TRAP      = 5'd16
`ifdef CU_ZICSR_EN
      ,
      S_CSR       = 5'd17
`endif
   } state_t;

   typedef struct packed {
      logic       pc_write;
      logic       pc_write_cond;
      logic       ir_write;
      logic       reg_write;
      logic       memory_read;
      logic       memory_write;
      logic       lorD;
      logic       memory_to_reg;
      logic       is_immediate;
      logic [1:0] pc_source;
      logic [1:0] aluop;
      logic [1:0] alu_src_a;
      logic [1:0] alu_src_b;
      logic       trap;
`ifdef CU_ZICSR_EN
      logic       csr_access;
`endif
   } ctl_t;

   localparam logic [TIMEOUT_W-1:0] TO_LAST =
      TIMEOUT_W'((MEM_TIMEOUT == 0) ? 0 : MEM_TIMEOUT - 1);

   state_t               state, nxt;
   ctl_t                 ctl_q, ctl_o;
   logic [TIMEOUT_W-1:0] wait_cnt;
   logic [3:0]           cause_nxt;
   logic                 in_wait, nxt_wait, to_fire;

   function automatic ctl_t decode(input state_t s);
      ctl_t c;
      c = '0;
      case (s)
         S_FETCH:     c.memory_read = 1'b1;
         S_FETCH_ACK: begin
            c.memory_read = 1'b1; c.ir_write = 1'b1; c.pc_write = 1'b1; c.alu_src_b = 2'b01;
         end
         S_DECODE:    begin c.alu_src_a = 2'b10; c.alu_src_b = 2'b10; end
         S_MEMADR:    begin c.alu_src_a = 2'b01; c.alu_src_b = 2'b10; end
         S_MEMREAD:   begin c.memory_read = 1'b1; c.lorD = 1'b1; end
         S_MEMWB:     begin c.reg_write = 1'b1; c.memory_to_reg = 1'b1; end
         S_MEMWRITE:  begin c.memory_write = 1'b1; c.lorD = 1'b1; end
         S_EXEC_R:    begin c.alu_src_a = 2'b01; c.aluop = 2'b10; end
         S_EXEC_I:    begin
            c.alu_src_a = 2'b01; c.alu_src_b = 2'b10; c.aluop = 2'b10; c.is_immediate = 1'b1;
         end
         S_ALUWB:     c.reg_write = 1'b1;
         S_JAL:       begin
            c.alu_src_a = 2'b10; c.alu_src_b = 2'b01; c.pc_write = 1'b1; c.pc_source = 2'b01;
         end
         S_BRANCH:    begin
            c.alu_src_a = 2'b01; c.aluop = 2'b01; c.pc_write_cond = 1'b1; c.pc_source = 2'b01;
         end
         S_JALR_PC:   begin c.alu_src_a = 2'b01; c.alu_src_b = 2'b10; c.is_immediate = 1'b1; end
         S_JALR:      begin
            c.alu_src_a = 2'b10; c.alu_src_b = 2'b01; c.pc_write = 1'b1; c.pc_source = 2'b01;
         end
         S_AUIPC:     begin c.alu_src_a = 2'b10; c.alu_src_b = 2'b10; end
         S_LUI:       begin c.alu_src_a = 2'b11; c.alu_src_b = 2'b10; end
         S_TRAP:      begin c.trap = 1'b1; c.pc_write = 1'b1; c.pc_source = 2'b10; end
`ifdef CU_ZICSR_EN
         S_CSR:       begin c.alu_src_a = 2'b01; c.reg_write = 1'b1; c.csr_access = 1'b1; end
`endif
         default:     c = '0;
      endcase
      return c;
   endfunction

   assign in_wait  = (state == S_FETCH) || (state == S_MEMREAD) || (state == S_MEMWRITE);
   assign nxt_wait = (nxt == S_FETCH) || (nxt == S_MEMREAD) || (nxt == S_MEMWRITE);
   // A response in the last allowed cycle beats the timeout.
   assign to_fire  = (MEM_TIMEOUT != 0) && (wait_cnt == TO_LAST) && !memory_response;

   always_comb begin
      nxt       = S_FETCH;
      cause_nxt = 4'd0;
      case (state)
         S_FETCH: begin
            if (memory_response)  nxt = S_FETCH_ACK;
            else if (to_fire)     begin nxt = S_TRAP; cause_nxt = 4'd1; end
            else                  nxt = S_FETCH;
         end
         S_FETCH_ACK: nxt = S_DECODE;
         S_DECODE: begin
            case (instruction_opcode)
               7'b0000011, 7'b0100011: nxt = S_MEMADR;
               7'b0110011: nxt = S_EXEC_R;
               7'b0010011: nxt = S_EXEC_I;
               7'b1101111: nxt = S_JAL;
               7'b1100011: nxt = S_BRANCH;
               7'b1100111: nxt = S_JALR_PC;
               7'b0010111: nxt = S_AUIPC;
               7'b0110111: nxt = S_LUI;
               7'b0001111: nxt = S_FETCH;
               7'b1110011: begin
                  if (instruction_funct3 == 3'd0) begin
                     nxt       = S_TRAP;
                     cause_nxt = instruction_bit20 ? 4'd3 : 4'd11;
                  end else begin
`ifdef CU_ZICSR_EN
                     nxt = S_CSR;
`else
                     nxt       = S_TRAP;
                     cause_nxt = 4'd2;
`endif
                  end
               end
               default: begin nxt = S_TRAP; cause_nxt = 4'd2; end
            endcase
         end
         S_MEMADR:  nxt = (instruction_opcode == 7'b0000011) ? S_MEMREAD : S_MEMWRITE;
         S_MEMREAD: begin
            if (memory_response)  nxt = S_MEMWB;
            else if (to_fire)     begin nxt = S_TRAP; cause_nxt = 4'd5; end
            else                  nxt = S_MEMREAD;
         end
         S_MEMWB:   nxt = S_FETCH;
         S_MEMWRITE: begin
            if (memory_response)  nxt = S_FETCH;
            else if (to_fire)     begin nxt = S_TRAP; cause_nxt = 4'd7; end
            else                  nxt = S_MEMWRITE;
         end
         S_EXEC_R, S_EXEC_I, S_JAL, S_JALR, S_AUIPC, S_LUI: nxt = S_ALUWB;
         S_ALUWB:   nxt = S_FETCH;
         S_BRANCH:  nxt = S_FETCH;
         S_JALR_PC: nxt = S_JALR;
         S_TRAP:    nxt = S_FETCH;
`ifdef CU_ZICSR_EN
         S_CSR:     nxt = S_FETCH;
`endif
         default:   nxt = S_FETCH;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= S_FETCH;
         ctl_q      <= decode(S_FETCH);
         wait_cnt   <= '0;
         trap_cause <= 4'd0;
      end else begin
         state <= nxt;
         ctl_q <= decode(nxt);
         if (nxt == S_TRAP)
            trap_cause <= cause_nxt;
         if (nxt_wait && (nxt != state))
            wait_cnt <= '0;
         else if (in_wait && !memory_response && (MEM_TIMEOUT != 0))
            wait_cnt <= wait_cnt + 1'b1;
      end
   end

   // Registered controls hold the FETCH decode across reset; gating keeps them low while reset is asserted.
   assign ctl_o = rst_n ? ctl_q : '0;

   assign pc_write      = ctl_o.pc_write;
   assign pc_write_cond = ctl_o.pc_write_cond;
   assign ir_write      = ctl_o.ir_write;
   assign reg_write     = ctl_o.reg_write;
   assign memory_read   = ctl_o.memory_read;
   assign memory_write  = ctl_o.memory_write;
   assign lorD          = ctl_o.lorD;
   assign memory_to_reg = ctl_o.memory_to_reg;
   assign is_immediate  = ctl_o.is_immediate;
   assign pc_source     = ctl_o.pc_source;
   assign aluop         = ctl_o.aluop;
   assign alu_src_a     = ctl_o.alu_src_a;
   assign alu_src_b     = ctl_o.alu_src_b;
   assign trap          = ctl_o.trap;
   assign state_dbg     = state;
`ifdef CU_ZICSR_EN
   assign csr_access    = ctl_o.csr_access;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: sequencing, timeouts, traps and async reset, MEM_TIMEOUT=4 plus a MEM_TIMEOUT=0 instance.
module tb_multicycle_ctrl;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       resp = 1'b0;
   logic [6:0] opcode = 7'd0;
   logic [2:0] f3 = 3'd0;
   logic       b20 = 1'b0;

   logic       pc_write, pc_write_cond, ir_write, reg_write, memory_read, memory_write;
   logic       lorD, memory_to_reg, is_immediate, trap;
   logic [1:0] pc_source, aluop, alu_src_a, alu_src_b;
   logic [3:0] trap_cause;
   logic [4:0] state_dbg;
`ifdef CU_ZICSR_EN
   logic       csr_access, n_csr;
`endif

   logic       n_pcw, n_pcwc, n_irw, n_rw, n_mr, n_mw, n_lord, n_m2r, n_imm, n_trap;
   logic [1:0] n_pcs, n_aop, n_a, n_b;
   logic [3:0] n_cause;
   logic [4:0] n_state;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   multicycle_ctrl #(.MEM_TIMEOUT(4), .TIMEOUT_W(8)) dut (
      .clk(clk), .rst_n(rst_n), .memory_response(resp),
      .instruction_opcode(opcode), .instruction_funct3(f3), .instruction_bit20(b20),
      .pc_write(pc_write), .pc_write_cond(pc_write_cond), .ir_write(ir_write), .reg_write(reg_write),
      .memory_read(memory_read), .memory_write(memory_write), .lorD(lorD),
      .memory_to_reg(memory_to_reg), .is_immediate(is_immediate), .pc_source(pc_source),
      .aluop(aluop), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .trap(trap),
      .trap_cause(trap_cause), .state_dbg(state_dbg)
`ifdef CU_ZICSR_EN
      , .csr_access(csr_access)
`endif
   );

   multicycle_ctrl #(.MEM_TIMEOUT(0), .TIMEOUT_W(8)) dut_nt (
      .clk(clk), .rst_n(rst_n), .memory_response(resp),
      .instruction_opcode(opcode), .instruction_funct3(f3), .instruction_bit20(b20),
      .pc_write(n_pcw), .pc_write_cond(n_pcwc), .ir_write(n_irw), .reg_write(n_rw),
      .memory_read(n_mr), .memory_write(n_mw), .lorD(n_lord),
      .memory_to_reg(n_m2r), .is_immediate(n_imm), .pc_source(n_pcs),
      .aluop(n_aop), .alu_src_a(n_a), .alu_src_b(n_b), .trap(n_trap),
      .trap_cause(n_cause), .state_dbg(n_state)
`ifdef CU_ZICSR_EN
      , .csr_access(n_csr)
`endif
   );

   function automatic logic [17:0] all_ctl();
      return {pc_write, pc_write_cond, ir_write, reg_write, memory_read, memory_write, lorD,
              memory_to_reg, is_immediate, pc_source, aluop, alu_src_a, alu_src_b, trap};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0; resp = 1'b0;
      tick(); tick();
      rst_n = 1'b1;
      #1;
   endtask

   // From a freshly entered FETCH: ack immediately, land in DECODE.
   task automatic fetch_to_decode(input logic [6:0] op, input logic [2:0] fn3, input logic bit20);
      opcode = op; f3 = fn3; b20 = bit20;
      resp = 1'b1; tick();
      resp = 1'b0; tick();
   endtask

   task automatic test_reset();
      rst_n = 1'b0; resp = 1'b0;
      tick(); tick();
      n_vec++; if (all_ctl() !== 18'd0) begin $display("FAIL reset_ctl: got %h want 0", all_ctl()); n_err++; end
      n_vec++; if (state_dbg !== 5'd0) begin $display("FAIL reset_state: got %0d want 0", state_dbg); n_err++; end
      n_vec++; if (trap_cause !== 4'd0) begin $display("FAIL reset_cause: got %0d want 0", trap_cause); n_err++; end
      rst_n = 1'b1; #1;
      n_vec++; if (memory_read !== 1'b1) begin $display("FAIL release_mread: got %b want 1", memory_read); n_err++; end
   endtask

   task automatic test_r_type();
      logic [4:0] exp_st [8] = '{5'd0, 5'd0, 5'd0, 5'd1, 5'd2, 5'd7, 5'd9, 5'd0};
      do_reset();
      opcode = 7'b0110011; f3 = 3'd0; b20 = 1'b0;
      for (int i = 0; i < 8; i++) begin
         n_vec++; if (state_dbg !== exp_st[i]) begin $display("FAIL rtype_state[%0d]: got %0d want %0d", i, state_dbg, exp_st[i]); n_err++; end
         n_vec++; if (reg_write !== (exp_st[i] == 5'd9)) begin $display("FAIL rtype_regw[%0d]: got %b want %b", i, reg_write, exp_st[i] == 5'd9); n_err++; end
         if (exp_st[i] == 5'd1) begin
            n_vec++; if ({ir_write, pc_write, alu_src_b} !== 4'b1101) begin $display("FAIL fetch_ack_ctl: got %b want 1101", {ir_write, pc_write, alu_src_b}); n_err++; end
         end
         if (exp_st[i] == 5'd7) begin
            n_vec++; if ({alu_src_a, aluop} !== 4'b0110) begin $display("FAIL exec_r_ctl: got %b want 0110", {alu_src_a, aluop}); n_err++; end
         end
         resp = (i == 2);
         tick();
      end
      resp = 1'b0;
   endtask

   task automatic test_load();
      fetch_to_decode(7'b0000011, 3'd2, 1'b0);
      n_vec++; if ({state_dbg, alu_src_a, alu_src_b} !== {5'd2, 2'b10, 2'b10}) begin $display("FAIL decode_ctl: got %b want 000101010", {state_dbg, alu_src_a, alu_src_b}); n_err++; end
      tick();
      n_vec++; if (state_dbg !== 5'd3) begin $display("FAIL load_memadr: got %0d want 3", state_dbg); n_err++; end
      tick();
      for (int i = 0; i < 4; i++) begin
         n_vec++; if ({state_dbg, memory_read, lorD} !== {5'd4, 2'b11}) begin $display("FAIL load_memread[%0d]: got %b want 0010011", i, {state_dbg, memory_read, lorD}); n_err++; end
         resp = (i == 3);
         tick();
      end
      resp = 1'b0;
      n_vec++; if ({state_dbg, reg_write, memory_to_reg} !== {5'd5, 2'b11}) begin $display("FAIL load_memwb: got %b want 0010111", {state_dbg, reg_write, memory_to_reg}); n_err++; end
      tick();
      n_vec++; if ({state_dbg, reg_write} !== 6'd0) begin $display("FAIL load_back_fetch: got %b want 000000", {state_dbg, reg_write}); n_err++; end
   endtask

   task automatic test_fetch_timeout();
      resp = 1'b0;
      for (int i = 0; i < 4; i++) begin
         n_vec++; if ({state_dbg, trap} !== 6'd0) begin $display("FAIL fto_wait[%0d]: got %b want 000000", i, {state_dbg, trap}); n_err++; end
         tick();
      end
      n_vec++; if ({state_dbg, trap, pc_write, pc_source, trap_cause} !== {5'd16, 1'b1, 1'b1, 2'b10, 4'd1}) begin
         $display("FAIL fto_trap: got %b want %b", {state_dbg, trap, pc_write, pc_source, trap_cause}, {5'd16, 1'b1, 1'b1, 2'b10, 4'd1}); n_err++; end
      tick();
      n_vec++; if ({state_dbg, trap, trap_cause} !== {5'd0, 1'b0, 4'd1}) begin $display("FAIL fto_hold: got %b want 0000000001", {state_dbg, trap, trap_cause}); n_err++; end
   endtask

   task automatic test_traps();
      logic [6:0] t_op [4] = '{7'b1111111, 7'b1110011, 7'b1110011, 7'b1110011};
      logic [2:0] t_f3 [4] = '{3'd0, 3'd0, 3'd0, 3'd1};
      logic       t_b  [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
      logic [3:0] t_c  [4] = '{4'd2, 4'd3, 4'd11, 4'd2};
      for (int i = 0; i < 4; i++) begin
         fetch_to_decode(t_op[i], t_f3[i], t_b[i]);
         tick();
`ifdef CU_ZICSR_EN
         if (i == 3) begin
            n_vec++; if ({state_dbg, csr_access, reg_write, alu_src_a} !== {5'd17, 2'b11, 2'b01}) begin $display("FAIL csr_state: got %b want 100011101", {state_dbg, csr_access, reg_write, alu_src_a}); n_err++; end
            tick();
            continue;
         end
`endif
         n_vec++; if ({state_dbg, trap, trap_cause} !== {5'd16, 1'b1, t_c[i]}) begin $display("FAIL trap_cause[%0d]: got %b want %b", i, {state_dbg, trap, trap_cause}, {5'd16, 1'b1, t_c[i]}); n_err++; end
         tick();
      end
      // Response arriving in the final allowed FETCH cycle must not trap.
      for (int i = 0; i < 4; i++) begin
         resp = (i == 3);
         tick();
      end
      resp = 1'b0;
      n_vec++; if ({state_dbg, trap} !== {5'd1, 1'b0}) begin $display("FAIL resp_wins: got %b want 000010", {state_dbg, trap}); n_err++; end
      opcode = 7'b0001111;
      tick(); tick();
      n_vec++; if (state_dbg !== 5'd0) begin $display("FAIL fence: got %0d want 0", state_dbg); n_err++; end
   endtask

   task automatic test_jalr();
      logic [4:0] exp_st [5] = '{5'd2, 5'd12, 5'd13, 5'd9, 5'd0};
      fetch_to_decode(7'b1100111, 3'd0, 1'b0);
      for (int i = 0; i < 5; i++) begin
         n_vec++; if (state_dbg !== exp_st[i]) begin $display("FAIL jalr_state[%0d]: got %0d want %0d", i, state_dbg, exp_st[i]); n_err++; end
         n_vec++; if (pc_write !== (exp_st[i] == 5'd13)) begin $display("FAIL jalr_pcw[%0d]: got %b want %b", i, pc_write, exp_st[i] == 5'd13); n_err++; end
         if (exp_st[i] == 5'd13) begin
            n_vec++; if (pc_source !== 2'b01) begin $display("FAIL jalr_pcsrc: got %b want 01", pc_source); n_err++; end
         end
         if (exp_st[i] == 5'd12) begin
            n_vec++; if ({alu_src_a, alu_src_b, is_immediate} !== 5'b01101) begin $display("FAIL jalr_pc_ctl: got %b want 01101", {alu_src_a, alu_src_b, is_immediate}); n_err++; end
         end
         tick();
      end
   endtask

   task automatic test_dispatch();
      // {state, a, b, aluop, pc_source, is_immediate, pc_write, pc_write_cond}
      logic [6:0]  d_op  [5] = '{7'b0010011, 7'b1101111, 7'b1100011, 7'b0010111, 7'b0110111};
      logic [15:0] d_exp [5] = '{{5'd8,  2'b01, 2'b10, 2'b10, 2'b00, 3'b100},
                                 {5'd10, 2'b10, 2'b01, 2'b00, 2'b01, 3'b010},
                                 {5'd11, 2'b01, 2'b00, 2'b01, 2'b01, 3'b001},
                                 {5'd14, 2'b10, 2'b10, 2'b00, 2'b00, 3'b000},
                                 {5'd15, 2'b11, 2'b10, 2'b00, 2'b00, 3'b000}};
      logic [4:0]  d_nxt [5] = '{5'd9, 5'd9, 5'd0, 5'd9, 5'd9};
      for (int i = 0; i < 5; i++) begin
         fetch_to_decode(d_op[i], 3'd0, 1'b0);
         tick();
         n_vec++; if ({state_dbg, alu_src_a, alu_src_b, aluop, pc_source, is_immediate, pc_write, pc_write_cond} !== d_exp[i]) begin
            $display("FAIL dispatch[%0d]: got %h want %h", i, {state_dbg, alu_src_a, alu_src_b, aluop, pc_source, is_immediate, pc_write, pc_write_cond}, d_exp[i]); n_err++; end
         tick();
         n_vec++; if (state_dbg !== d_nxt[i]) begin $display("FAIL dispatch_next[%0d]: got %0d want %0d", i, state_dbg, d_nxt[i]); n_err++; end
         if (d_nxt[i] == 5'd9) tick();
      end
   endtask

   task automatic test_store_timeout();
      fetch_to_decode(7'b0100011, 3'd2, 1'b0);
      tick(); tick();
      for (int i = 0; i < 4; i++) begin
         n_vec++; if ({state_dbg, memory_write, lorD, memory_read} !== {5'd6, 3'b110}) begin $display("FAIL store_wait[%0d]: got %b want 00110110", i, {state_dbg, memory_write, lorD, memory_read}); n_err++; end
         tick();
      end
      n_vec++; if ({state_dbg, trap_cause} !== {5'd16, 4'd7}) begin $display("FAIL store_timeout: got %b want 100000111", {state_dbg, trap_cause}); n_err++; end
      tick();
   endtask

   task automatic test_reset_midop();
      fetch_to_decode(7'b0100011, 3'd2, 1'b0);
      tick(); tick(); tick();
      n_vec++; if (state_dbg !== 5'd6) begin $display("FAIL midop_setup: got %0d want 6", state_dbg); n_err++; end
      rst_n = 1'b0; #1;
      n_vec++; if (all_ctl() !== 18'd0) begin $display("FAIL midop_ctl: got %h want 0", all_ctl()); n_err++; end
      n_vec++; if ({state_dbg, trap_cause} !== 9'd0) begin $display("FAIL midop_state: got %b want 0", {state_dbg, trap_cause}); n_err++; end
      tick();
      rst_n = 1'b1; #1;
      n_vec++; if ({state_dbg, memory_read, memory_write} !== {5'd0, 2'b10}) begin $display("FAIL midop_release: got %b want 0000010", {state_dbg, memory_read, memory_write}); n_err++; end
   endtask

   task automatic test_no_timeout();
      do_reset();
      for (int i = 0; i < 12; i++) tick();
      n_vec++; if ({n_state, n_trap, n_cause, n_mr} !== {5'd0, 1'b0, 4'd0, 1'b1}) begin $display("FAIL nt_state: got %b want 00000000001", {n_state, n_trap, n_cause, n_mr}); n_err++; end
      n_vec++; if (trap_cause !== 4'd1) begin $display("FAIL nt_ref_cause: got %0d want 1", trap_cause); n_err++; end
   endtask

   initial begin
      test_reset();
      test_r_type();
      test_load();
      test_fetch_timeout();
      test_traps();
      test_jalr();
      test_dispatch();
      test_store_timeout();
      test_reset_midop();
      test_no_timeout();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
